// File: rtl/arb_mux_n_if.sv
// Handshake bundle between N input channels, the arbiter/mux, and one downstream consumer.
// master = the side that offers words and consumes the output; slave = the arbiter.
interface arb_mux_n_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/arb_mux_n.sv
// N-to-1 arbitrated mux with a single registered output slot; round-robin (MODE=0)
// or fixed lowest-index priority (MODE=1).
module arb_mux_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0
) (
  input logic        clk,
  input logic        rst,
  arb_mux_n_if.slave bus
);
  localparam int SELW = $clog2(N);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  start;
  logic [SELW-1:0]  gsel;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] gdata;
  logic             found;
  logic             load;
  int               c;

  assign load  = !bus.out_valid || bus.out_ready;
  assign start = (MODE == 0) ? ptr : '0;

  // Search ptr, ptr+1, ... wrapping at N (not at 2**SELW) so non-power-of-two N works.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gsel  = '0;
    gdata = '0;
    c     = 0;
    if (load && !rst) begin
      for (int k = 0; k < N; k++) begin
        c = int'(start) + k;
        if (c >= N) c = c - N;
        if (!found && bus.in_valid[SELW'(c)]) begin
          found          = 1'b1;
          grant[SELW'(c)] = 1'b1;
          gsel           = SELW'(c);
          gdata          = WIDTH'(bus.in_data >> (c * WIDTH));
        end
      end
    end
  end

  assign bus.in_ready = grant;

  // Output slot: loads on grant, empties when nothing is offered, holds under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      ptr           <= '0;
    end else if (load) begin
      bus.out_valid <= found;
      if (found) begin
        bus.out_data <= gdata;
        bus.out_sel  <= gsel;
        if (MODE == 0) ptr <= (int'(gsel) == N - 1) ? '0 : gsel + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: a round-robin and a fixed-priority instance share one stimulus
// stream and are each compared against a behavioural model of the arbitration rules.
module tb_arb_mux_n;
  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  arb_mux_n_if #(.WIDTH(8), .N(4)) if0 ();
  arb_mux_n_if #(.WIDTH(8), .N(4)) if1 ();

  assign if0.in_data = in_data;  assign if1.in_data = in_data;
  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  arb_mux_n #(.WIDTH(8), .N(4), .MODE(0)) dut_rr (.clk(clk), .rst(rst), .bus(if0));
  arb_mux_n #(.WIDTH(8), .N(4), .MODE(1)) dut_fp (.clk(clk), .rst(rst), .bus(if1));

  logic [3:0] rdy [2];
  logic       ov  [2];
  logic [7:0] od  [2];
  logic [1:0] os  [2];
  assign rdy[0] = if0.in_ready;  assign rdy[1] = if1.in_ready;
  assign ov[0]  = if0.out_valid; assign ov[1]  = if1.out_valid;
  assign od[0]  = if0.out_data;  assign od[1]  = if1.out_data;
  assign os[0]  = if0.out_sel;   assign os[1]  = if1.out_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: index 0 = round-robin instance, 1 = fixed-priority instance.
  int         mptr [2];
  logic       mval [2];
  logic [7:0] mdat [2];
  int         msel [2];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      mptr[m] = 0; mval[m] = 1'b0; mdat[m] = 8'h00; msel[m] = 0;
    end
  endfunction

  function automatic logic [3:0] exp_ready(int m);
    int first;
    if (rst) return 4'b0000;
    if (mval[m] && !out_ready) return 4'b0000;
    first = (m == 0) ? mptr[m] : 0;
    for (int k = 0; k < 4; k++) begin
      if (in_valid[(first + k) % 4]) return 4'(1 << ((first + k) % 4));
    end
    return 4'b0000;
  endfunction

  task automatic tick();
    logic [3:0]  g [2];
    logic        ld [2];
    logic [31:0] din;
    logic        was_rst;
    for (int m = 0; m < 2; m++) begin
      g[m]  = exp_ready(m);
      ld[m] = !mval[m] || out_ready;
    end
    din = in_data;
    was_rst = rst;
    @(posedge clk);
    #1;
    if (!was_rst) begin
      for (int m = 0; m < 2; m++) begin
        if (ld[m]) begin
          if (g[m] != 4'b0000) begin
            for (int ch = 0; ch < 4; ch++) begin
              if (g[m][ch]) begin
                mval[m] = 1'b1;
                mdat[m] = din[ch*8 +: 8];
                msel[m] = ch;
                if (m == 0) mptr[m] = (ch + 1) % 4;
              end
            end
          end else begin
            mval[m] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; in_data = 32'h33221100;
    model_reset();
    #12;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (ov[m] !== 1'b0 || od[m] !== 8'h00 || os[m] !== 2'd0 || rdy[m] !== 4'b0000) begin
        bad++;
        $display("FAIL reset m%0d: got v=%b d=%h s=%0d rdy=%b, expected all zero", m, ov[m], od[m], os[m], rdy[m]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] sel_seq [5];
    logic [7:0] dat_seq [5];
    sel_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    dat_seq = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (rdy[0] !== 4'b0001) begin
      bad++; $display("FAIL rr_first_grant: got %b expected 0001", rdy[0]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (ov[0] !== 1'b1 || os[0] !== sel_seq[i] || od[0] !== dat_seq[i]) begin
        bad++;
        $display("FAIL rr_seq[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h", i, ov[0], os[0], od[0], sel_seq[i], dat_seq[i]);
      end
      total++;
      if (ov[1] !== mval[1] || os[1] !== 2'(msel[1]) || od[1] !== mdat[1]) begin
        bad++;
        $display("FAIL fp_seq[%0d]: got v=%b s=%0d d=%h expected v=%b s=%0d d=%h", i, ov[1], os[1], od[1], mval[1], msel[1], mdat[1]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] sel_seq [3];
    sel_seq = '{2'd0, 2'd1, 2'd0};
    in_valid = 4'b0100;
    tick();
    total++;
    if (os[0] !== 2'd2) begin
      bad++; $display("FAIL wrap_setup: got s=%0d expected 2", os[0]);
    end
    in_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (os[0] !== sel_seq[i] || ov[0] !== 1'b1) begin
        bad++; $display("FAIL wrap[%0d]: got v=%b s=%0d expected v=1 s=%0d", i, ov[0], os[0], sel_seq[i]);
      end
      total++;
      if (os[1] !== 2'd0) begin
        bad++; $display("FAIL wrap_fp[%0d]: got s=%0d expected 0", i, os[1]);
      end
    end
  endtask

  task automatic test_stall();
    in_data = 32'h3322115A; in_valid = 4'b0001; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        total++;
        if (rdy[m] !== 4'b0000) begin
          bad++; $display("FAIL stall_ready[%0d] m%0d: got %b expected 0000", i, m, rdy[m]);
        end
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        total++;
        if (ov[m] !== 1'b1 || od[m] !== 8'h5A || os[m] !== 2'd0) begin
          bad++; $display("FAIL stall_hold[%0d] m%0d: got v=%b d=%h s=%0d expected v=1 d=5a s=0", i, m, ov[m], od[m], os[m]);
        end
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (rdy[0] !== 4'b0010) begin
      bad++; $display("FAIL stall_release_grant: got %b expected 0010", rdy[0]);
    end
    tick();
    total++;
    if (od[0] !== 8'h11 || os[0] !== 2'd1 || ov[0] !== 1'b1) begin
      bad++; $display("FAIL stall_release_load: got v=%b d=%h s=%0d expected v=1 d=11 s=1", ov[0], od[0], os[0]);
    end
  endtask

  task automatic test_fixed_priority();
    in_valid = 4'b1110; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (rdy[1] !== 4'b0010) begin
        bad++; $display("FAIL fp_ready[%0d]: got %b expected 0010", i, rdy[1]);
      end
      tick();
      total++;
      if (os[1] !== 2'd1 || od[1] !== 8'h11) begin
        bad++; $display("FAIL fp_sel[%0d]: got s=%0d d=%h expected s=1 d=11", i, os[1], od[1]);
      end
      total++;
      if (os[0] !== 2'(msel[0]) || od[0] !== mdat[0]) begin
        bad++; $display("FAIL fp_rr_side[%0d]: got s=%0d d=%h expected s=%0d d=%h", i, os[0], od[0], msel[0], mdat[0]);
      end
    end
  endtask

  task automatic test_drain();
    in_data = 32'h44332277; in_valid = 4'b0001; out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    tick();
    for (int m = 0; m < 2; m++) begin
      total++;
      if (ov[m] !== 1'b0 || od[m] !== 8'h77 || os[m] !== 2'd0) begin
        bad++; $display("FAIL drain m%0d: got v=%b d=%h s=%0d expected v=0 d=77 s=0", m, ov[m], od[m], os[m]);
      end
    end
  endtask

  task automatic test_async_reset();
    in_data = 32'hD4C3B2A1; in_valid = 4'b1111; out_ready = 1'b1;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      total++;
      if (ov[m] !== 1'b0 || od[m] !== 8'h00 || os[m] !== 2'd0 || rdy[m] !== 4'b0000) begin
        bad++; $display("FAIL async_reset m%0d: got v=%b d=%h s=%0d rdy=%b expected zeros", m, ov[m], od[m], os[m], rdy[m]);
      end
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (rdy[0] !== 4'b0001) begin
      bad++; $display("FAIL async_restart_grant: got %b expected 0001", rdy[0]);
    end
    tick();
    total++;
    if (os[0] !== 2'd0 || od[0] !== 8'hA1 || ov[0] !== 1'b1) begin
      bad++; $display("FAIL async_restart: got v=%b s=%0d d=%h expected v=1 s=0 d=a1", ov[0], os[0], od[0]);
    end
  endtask

  task automatic test_random();
    int cnt_bad_before;
    cnt_bad_before = bad;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        total++;
        if (rdy[m] !== exp_ready(m) || !$onehot0(rdy[m])) begin
          bad++; $display("FAIL rand_ready[%0d] m%0d: got %b expected %b", i, m, rdy[m], exp_ready(m));
        end
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        total++;
        if (ov[m] !== mval[m] || od[m] !== mdat[m] || os[m] !== 2'(msel[m])) begin
          bad++;
          $display("FAIL rand_out[%0d] m%0d: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d", i, m, ov[m], od[m], os[m], mval[m], mdat[m], msel[m]);
        end
      end
      if (bad - cnt_bad_before > 10) break;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_stall();
    test_fixed_priority();
    test_drain();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data bits per channel (>=1).
REQ-002 SHALL provide parameter N, default 4, number of input channels (2..16).
REQ-003 SHALL provide parameter MODE, default 0; 0 = round-robin arbitration, 1 = fixed priority with lowest index winning.
REQ-004 SHALL derive local SELW = clog2(N).
REQ-005 Port: clk  input  1  single clock; all state on rising edge.
REQ-006 Port: rst  input  1  asynchronous, active-high reset.
REQ-007 Port: in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port: in_valid  input  N  channel i offers a word.
REQ-009 Port: in_ready  output  N  channel i word accepted this cycle.
REQ-010 Port: out_data  output  WIDTH  registered selected word.
REQ-011 Port: out_valid  output  1  out_data holds an unconsumed word.
REQ-012 Port: out_sel  output  SELW  source channel index of out_data.
REQ-013 Port: out_ready  input  1  downstream accepts out_data.

Function
REQ-014 SHALL define load = !out_valid || out_ready; the output register may take a new word only when load=1.
REQ-015 SHALL grant at most one channel per cycle; grant is combinational from in_valid, priority pointer, MODE and load.
REQ-016 SHALL drive in_ready[i]=1 only for the granted channel; in_ready SHALL be one-hot or zero and SHALL NOT depend on in_valid of the same channel beyond grant selection.
REQ-017 A transfer on channel i SHALL occur when in_valid[i] && in_ready[i]; next edge loads out_data=word i, out_sel=i, out_valid=1 (latency 1 cycle).
REQ-018 If load=1 and no in_valid bit set, out_valid SHALL go 0 on next edge; out_data and out_sel SHALL hold their last values.
REQ-019 If out_valid=1 and out_ready=0, out_data, out_sel, out_valid SHALL hold stable and all in_ready SHALL be 0.
REQ-020 Simultaneous consume and load (out_valid=1, out_ready=1, a valid input) SHALL sustain one word per cycle with no bubble.
REQ-021 MODE=0: pointer ptr (SELW bits) names the highest-priority channel; search order ptr, ptr+1, ..., wrapping N-1 to 0.
REQ-022 MODE=0: after a transfer from channel i, ptr SHALL become i+1, wrapping to 0 when i=N-1 (including non-power-of-two N); ptr SHALL NOT change in cycles without a transfer.
REQ-023 MODE=1: lowest-index valid channel SHALL win; ptr is unused and held at 0.
REQ-024 A channel that drops in_valid before being granted SHALL be skipped without a transfer or pointer change.

Reset
REQ-025 On rst=1, asynchronously: out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready SHALL be all 0 while rst=1.
REQ-026 Reset asserted while out_valid=1 SHALL discard the held word; no in_ready pulse SHALL occur in the cycle reset deasserts unless load and in_valid conditions hold after deassertion.
REQ-027 First arbitration after reset in MODE=0 SHALL start from channel 0.

Verification (N=4, WIDTH=8)
REQ-028 Reset then in_valid=4'b1111, data {0x33,0x22,0x11,0x00}, out_ready=1, MODE=0 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 0x00,0x11,0x22,0x33,0x00, no bubbles.
REQ-029 MODE=0, ptr=3, in_valid=4'b0011 -> grant ch0 (wrap), then ch1, then ch0.
REQ-030 out_valid=1 with out_data=0x5A, out_ready=0 for 3 cycles, all in_valid=1 -> out_data stays 0x5A, in_ready=0 all 3 cycles; out_ready=1 -> next word loads next edge.
REQ-031 MODE=1, in_valid=4'b1110 continuously, out_ready=1 -> out_sel=1 every cycle; ch2/ch3 never granted.
REQ-032 in_valid=0, out_ready=1 after one word -> out_valid falls to 0 next edge, out_data holds last value.
REQ-033 rst pulsed mid-stream between clock edges with out_valid=1 -> out_valid=0, out_sel=0, out_data=0 immediately; after release, arbitration restarts at ch0.
